// File: rtl/vwb_sequencer.sv
// Vector writeback sequencer: walks an LMUL register group, applying vl-based tail
// policy per element, and issues one register-file write per accepted ALU beat.
module vwb_sequencer #(
  parameter int VLEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_vd,
  input  logic [3:0]       cmd_lmul,
  input  logic [2:0]       cmd_sew,
  input  logic [7:0]       cmd_vl,
  input  logic             cmd_vta,
  input  logic             beat_valid,
  output logic             beat_ready,
  input  logic [VLEN-1:0]  beat_data,
  input  logic [VLEN-1:0]  beat_old,
  output logic             wen,
  output logic [4:0]       wa,
  output logic [VLEN-1:0]  wd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int NB = VLEN / 8;

  typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       k_reg;
  logic [4:0]       vd_reg;
  logic [3:0]       lmul_reg;
  logic [1:0]       sew_reg;
  logic [7:0]       vl_reg;
  logic             vta_reg;
  logic             wen_reg;
  logic [4:0]       wa_reg;
  logic [VLEN-1:0]  wd_reg;

  logic             cmd_fire, beat_fire, last_beat;
  logic             lmul_ok, misaligned, overflow, cmd_illegal;
  logic [7:0]       vlmax, vl_eff;
  logic [7:0]       base_idx;
  logic [VLEN-1:0]  merged;

  // Command legality is judged on the live inputs so the decision lands in the accept cycle.
  assign lmul_ok     = (cmd_lmul == 4'd1) || (cmd_lmul == 4'd2) ||
                       (cmd_lmul == 4'd4) || (cmd_lmul == 4'd8);
  assign misaligned  = (cmd_vd & ({1'b0, cmd_lmul} - 5'd1)) != 5'd0;
  assign overflow    = ({1'b0, cmd_vd} + {2'b0, cmd_lmul}) > 6'd32;
  assign cmd_illegal = (cmd_sew > 3'd3) || !lmul_ok || misaligned || overflow;

  // VLMAX = lmul * (8 >> sew); vl beyond it is silently clamped.
  assign vlmax  = {4'b0, cmd_lmul} << (2'd3 - cmd_sew[1:0]);
  assign vl_eff = (cmd_vl < vlmax) ? cmd_vl : vlmax;

  assign cmd_fire  = cmd_valid && (state_reg == IDLE);
  assign beat_fire = beat_valid && (state_reg == RUN);
  assign last_beat = ({1'b0, k_reg} == (lmul_reg - 4'd1));

  // First element index carried by this beat: k * EPR == (k * 8) >> sew.
  assign base_idx = {2'b0, k_reg, 3'b0} >> sew_reg;

  // SEW is a whole number of bytes, so tail policy can be decided byte by byte.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      logic [2:0] byte_pos;
      logic [2:0] elem_j;
      logic [7:0] elem_idx;
      assign byte_pos = 3'(gi);
      assign elem_j   = byte_pos >> sew_reg;
      assign elem_idx = base_idx + {5'b0, elem_j};
      assign merged[gi*8 +: 8] = (elem_idx < vl_reg) ? beat_data[gi*8 +: 8] :
                                 (vta_reg ? 8'hFF : beat_old[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    beat_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_illegal)          state_next = ERR;
          else if (cmd_vl == 8'd0)  state_next = FIN;
          else                      state_next = RUN;
        end
      end
      RUN: begin
        beat_ready = 1'b1;
        if (beat_valid && last_beat) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k_reg    <= '0;
      vd_reg   <= '0;
      lmul_reg <= '0;
      sew_reg  <= '0;
      vl_reg   <= '0;
      vta_reg  <= 1'b0;
      wen_reg  <= 1'b0;
      wa_reg   <= '0;
      wd_reg   <= '0;
    end else begin
      wen_reg <= 1'b0;
      if (cmd_fire) begin
        k_reg    <= '0;
        vd_reg   <= cmd_vd;
        lmul_reg <= cmd_lmul;
        sew_reg  <= cmd_sew[1:0];
        vl_reg   <= vl_eff;
        vta_reg  <= cmd_vta;
      end
      if (beat_fire) begin
        k_reg   <= k_reg + 3'd1;
        wen_reg <= 1'b1;
        wa_reg  <= vd_reg + {2'b0, k_reg};
        wd_reg  <= merged;
      end
    end
  end

  assign wen = wen_reg;
  assign wa  = wa_reg;
  assign wd  = wd_reg;

endmodule

// File: tb/tb_vwb_sequencer.sv
// Directed and randomized bench for vwb_sequencer, checked against an element-level
// reference model of the tail-merge and command-legality rules.
module tb_vwb_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_vd = '0;
  logic [3:0]  cmd_lmul = '0;
  logic [2:0]  cmd_sew = '0;
  logic [7:0]  cmd_vl = '0;
  logic        cmd_vta = 1'b0;
  logic        beat_valid = 1'b0;
  logic        beat_ready;
  logic [63:0] beat_data = '0;
  logic [63:0] beat_old = '0;
  logic        wen;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] last_wd;

  vwb_sequencer #(.VLEN(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vd(cmd_vd), .cmd_lmul(cmd_lmul), .cmd_sew(cmd_sew),
    .cmd_vl(cmd_vl), .cmd_vta(cmd_vta),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_data(beat_data), .beat_old(beat_old),
    .wen(wen), .wa(wa), .wd(wd),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_illegal(int vd, int lmul, int sew);
    if (sew > 3) return 1'b1;
    if (!(lmul == 1 || lmul == 2 || lmul == 4 || lmul == 8)) return 1'b1;
    if (vd % lmul != 0) return 1'b1;
    if (vd + lmul > 32) return 1'b1;
    return 1'b0;
  endfunction

  // Each bit belongs to element (b / SEW); that element's global index decides body vs tail.
  function automatic logic [63:0] model_wd(int k, int lmul, int sew, int vl, bit vta,
                                          logic [63:0] d, logic [63:0] o);
    int sewb  = 8 << sew;
    int epr   = 64 / sewb;
    int vleff = (vl < lmul * epr) ? vl : lmul * epr;
    logic [63:0] r;
    for (int b = 0; b < 64; b++) begin
      int idx = k * epr + b / sewb;
      r[b] = (idx < vleff) ? d[b] : (vta ? 1'b1 : o[b]);
    end
    return r;
  endfunction

  task automatic issue(input int vd, input int lmul, input int sew, input int vl, input bit vta);
    cmd_valid = 1'b1;
    cmd_vd    = 5'(vd);
    cmd_lmul  = 4'(lmul);
    cmd_sew   = 3'(sew);
    cmd_vl    = 8'(vl);
    cmd_vta   = vta;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    chk("beat_ready_idle", 64'(beat_ready), 64'd0);
    tick;
    cmd_valid = 1'b0;
    cmd_vd    = 5'($urandom);
    cmd_lmul  = 4'($urandom);
  endtask

  task automatic send_beat(input int k, input int vd, input int lmul, input int sew,
                           input int vl, input bit vta, input int gaps, input bit fixed);
    logic [63:0] d, o, exp_wd;
    logic [4:0]  exp_wa;
    repeat ($urandom_range(0, gaps)) begin
      beat_valid = 1'b0;
      beat_data  = {$urandom, $urandom};
      tick;
      chk("gap_wen", 64'(wen), 64'd0);
      chk("gap_beat_ready", 64'(beat_ready), 64'd1);
    end
    d = fixed ? 64'h1111111111111111 : {$urandom, $urandom};
    o = fixed ? 64'hAAAAAAAAAAAAAAAA : {$urandom, $urandom};
    beat_valid = 1'b1;
    beat_data  = d;
    beat_old   = o;
    chk("beat_ready_run", 64'(beat_ready), 64'd1);
    chk("busy_run", 64'(busy), 64'd1);
    tick;
    beat_valid = 1'b0;
    exp_wa = 5'(vd + k);
    exp_wd = model_wd(k, lmul, sew, vl, vta, d, o);
    chk("wr_wen", 64'(wen), 64'd1);
    chk("wr_wa", 64'(wa), 64'(exp_wa));
    chk("wr_wd", wd, exp_wd);
    chk("wr_done", 64'(done), 64'(k == lmul - 1));
    last_wd = wd;
  endtask

  task automatic run_cmd(input int vd, input int lmul, input int sew, input int vl,
                         input bit vta, input int gaps, input bit fixed);
    bit bad = model_illegal(vd, lmul, sew);
    $display("cmd vd=%0d lmul=%0d sew=%0d vl=%0d vta=%0d illegal=%0d", vd, lmul, sew, vl, vta, bad);
    issue(vd, lmul, sew, vl, vta);
    if (bad) begin
      chk("err_done", 64'(done), 64'd1);
      chk("err_err", 64'(err), 64'd1);
      chk("err_wen", 64'(wen), 64'd0);
      chk("err_busy", 64'(busy), 64'd1);
    end else if (vl == 0) begin
      chk("vl0_done", 64'(done), 64'd1);
      chk("vl0_err", 64'(err), 64'd0);
      chk("vl0_wen", 64'(wen), 64'd0);
    end else begin
      for (int k = 0; k < lmul; k++) send_beat(k, vd, lmul, sew, vl, vta, gaps, fixed);
      chk("fin_err", 64'(err), 64'd0);
    end
    tick;
    chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_done", 64'(done), 64'd0);
    chk("post_err", 64'(err), 64'd0);
    chk("post_wen", 64'(wen), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int lmul_tab [8] = '{1, 2, 4, 8, 8, 4, 3, 0};
    rst = 1'b0;
    beat_valid = 1'b1;
    cmd_valid  = 1'b1;
    tick; tick;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_beat_ready", 64'(beat_ready), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wa", 64'(wa), 64'd0);
    chk("rst_wd", wd, 64'd0);
    beat_valid = 1'b0;
    cmd_valid  = 1'b0;
    rst = 1'b1;
    tick;

    // Byte elements, single register, tail undisturbed.
    run_cmd(4, 1, 0, 5, 1'b0, 0, 1'b1);
    chk("t1_literal_wd", last_wd, 64'hAAAAAA1111111111);
    // 32-bit elements over four registers, tail agnostic, back-to-back beats.
    run_cmd(8, 4, 2, 5, 1'b1, 0, 1'b0);
    run_cmd(2, 2, 1, 0, 1'b0, 0, 1'b0);
    run_cmd(6, 4, 0, 9, 1'b0, 0, 1'b0);
    run_cmd(0, 1, 5, 3, 1'b0, 0, 1'b0);
    run_cmd(0, 3, 0, 3, 1'b0, 0, 1'b0);
    // vl far beyond VLMAX with random handshake gaps.
    run_cmd(16, 8, 3, 200, 1'b1, 3, 1'b0);
    run_cmd(24, 8, 0, 255, 1'b0, 2, 1'b0);

    // Reset in the middle of a four-beat group, with a beat being offered.
    $display("cmd vd=12 lmul=4 sew=1 vl=10 vta=0 reset after 2 beats");
    issue(12, 4, 1, 10, 1'b0);
    send_beat(0, 12, 4, 1, 10, 1'b0, 0, 1'b0);
    send_beat(1, 12, 4, 1, 10, 1'b0, 0, 1'b0);
    beat_valid = 1'b1;
    rst = 1'b0;
    tick;
    chk("midrst_wen", 64'(wen), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_beat_ready", 64'(beat_ready), 64'd0);
    rst = 1'b1;
    beat_valid = 1'b0;
    tick;
    chk("midrst_idle_wen", 64'(wen), 64'd0);
    run_cmd(12, 4, 1, 10, 1'b0, 1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int lmul = lmul_tab[$urandom_range(0, 7)];
      int sew  = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
      int vd   = $urandom_range(0, 31);
      int vl   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
      if (lmul != 0 && lmul != 3 && $urandom_range(0, 4) != 0) vd = (vd / lmul) * lmul;
      if ($urandom_range(0, 2) == 0) vl = $urandom_range(1, 16);
      run_cmd(vd, lmul, sew, vl, 1'($urandom), $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
